// File: rtl/tablero_pkg.sv
// Shared types and helpers for the two 5x5 game boards and their commit arbiter.
package tablero_pkg;

  localparam int unsigned FILAS    = 5;
  localparam int unsigned COLUMNAS = 5;
  localparam int unsigned CELDAS   = FILAS * COLUMNAS;
  localparam int unsigned ANCHO    = 2 * CELDAS;

  typedef enum logic [1:0] {
    AGUA    = 2'd0,
    BARCO   = 2'd1,
    IMPACTO = 2'd2,
    FALLO   = 2'd3
  } celda_t;

  typedef enum logic [1:0] {
    StEspera   = 2'd0,
    StLimpieza = 2'd1,
    StVentana  = 2'd2
  } estado_t;

  // Low bit of cell (fila, col) in the flat board vector.
  function automatic int unsigned indice(input logic [2:0] fila, input logic [2:0] col);
    return 2 * (COLUMNAS * int'(fila) + int'(col));
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop synchroniser for the 25 MHz vsync plus a falling-edge pulse.
module detector_flanco (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic flanco
);

  logic s1_q, s2_q, s3_q;

  // Reset to the idle-high level so leaving reset never fakes a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= entrada;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign flanco = s3_q & ~s2_q;

endmodule

// File: rtl/arbitro_tablero.sv
// Round-robin cell-write arbiter and board storage for the VGA boards.
// Define VBLANK_COMMIT_EN to gate commits to a window opened at each vsync fall.
module arbitro_tablero
  import tablero_pkg::*;
#(
  parameter int unsigned MAX_WRITES = 4,
  parameter int unsigned WIN_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        req_j,
  input  logic        req_pc,
  input  logic        tab_j,
  input  logic        tab_pc,
  input  logic [2:0]  fila_j,
  input  logic [2:0]  fila_pc,
  input  logic [2:0]  col_j,
  input  logic [2:0]  col_pc,
  input  logic [1:0]  val_j,
  input  logic [1:0]  val_pc,
  input  logic        limpiar,
  output logic        ack_j,
  output logic        ack_pc,
  output logic        err_coord,
  output logic        ventana,
  output logic [49:0] tablero_jugador,
  output logic [49:0] tablero_pc
);

  logic [ANCHO-1:0] tab_jug_q, tab_jug_d, tab_pc_q, tab_pc_d;
  logic             ack_j_q, ack_pc_q, err_q, ptr_q, ptr_d;
  logic             habilita, limpia;
  logic             elig_j, elig_pc, gnt_j, gnt_pc, gnt, coord_ok;
  logic             tab_s;
  logic [2:0]       fila_s, col_s;
  logic [1:0]       val_s;

`ifdef VBLANK_COMMIT_EN
  localparam int unsigned CycW = $clog2(WIN_CYCLES + 1);

  estado_t         estado_q, estado_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic            pend_q, pend_d;
  logic            flanco;

  detector_flanco u_detector (
    .clock  (clock),
    .reset  (reset),
    .entrada(vsync),
    .flanco (flanco)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StEspera;
      cnt_q    <= '0;
      cyc_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    pend_d   = pend_q | limpiar;
    limpia   = 1'b0;
    habilita = 1'b0;
    unique case (estado_q)
      StEspera: begin
        cnt_d = '0;
        cyc_d = '0;
        if (flanco) estado_d = pend_q ? StLimpieza : StVentana;
      end
      StLimpieza: begin
        limpia   = 1'b1;
        pend_d   = limpiar;
        estado_d = StVentana;
      end
      StVentana: begin
        habilita = 1'b1;
        cyc_d    = cyc_q + 1'b1;
        if (gnt) cnt_d = cnt_q + 4'd1;
        if ((gnt && (cnt_q + 4'd1 == 4'(MAX_WRITES))) || (cyc_q == CycW'(WIN_CYCLES - 1))) begin
          estado_d = StEspera;
        end
      end
      default: estado_d = StEspera;
    endcase
  end

  assign ventana = (estado_q != StEspera);
`else
  localparam int unsigned unused_params = MAX_WRITES + WIN_CYCLES;
  logic unused_vsync;

  assign unused_vsync = vsync;
  // Without a window a clear takes the next edge and steals that cycle's grant.
  assign limpia   = limpiar;
  assign habilita = ~limpiar;
  assign ventana  = 1'b1;
`endif

  assign elig_j  = req_j & ~ack_j_q;
  assign elig_pc = req_pc & ~ack_pc_q;
  assign gnt_j   = habilita & elig_j & (~elig_pc | ~ptr_q);
  assign gnt_pc  = habilita & elig_pc & (~elig_j | ptr_q);
  assign gnt     = gnt_j | gnt_pc;

  assign tab_s    = gnt_pc ? tab_pc : tab_j;
  assign fila_s   = gnt_pc ? fila_pc : fila_j;
  assign col_s    = gnt_pc ? col_pc : col_j;
  assign val_s    = gnt_pc ? val_pc : val_j;
  assign coord_ok = (fila_s <= 3'(FILAS - 1)) && (col_s <= 3'(COLUMNAS - 1));

  always_comb begin
    tab_jug_d = tab_jug_q;
    tab_pc_d  = tab_pc_q;
    ptr_d     = ptr_q;
    if (gnt_j) ptr_d = 1'b1;
    else if (gnt_pc) ptr_d = 1'b0;
    if (limpia) begin
      tab_jug_d = '0;
      tab_pc_d  = '0;
    end else if (gnt && coord_ok) begin
      if (tab_s) tab_pc_d[indice(fila_s, col_s) +: 2] = val_s;
      else       tab_jug_d[indice(fila_s, col_s) +: 2] = val_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tab_jug_q <= '0;
      tab_pc_q  <= '0;
      ack_j_q   <= 1'b0;
      ack_pc_q  <= 1'b0;
      err_q     <= 1'b0;
      ptr_q     <= 1'b0;
    end else begin
      tab_jug_q <= tab_jug_d;
      tab_pc_q  <= tab_pc_d;
      ack_j_q   <= gnt_j;
      ack_pc_q  <= gnt_pc;
      err_q     <= gnt & ~coord_ok;
      ptr_q     <= ptr_d;
    end
  end

  assign ack_j           = ack_j_q;
  assign ack_pc          = ack_pc_q;
  assign err_coord       = err_q;
  assign tablero_jugador = tab_jug_q;
  assign tablero_pc      = tab_pc_q;

endmodule

// File: tb/tb_arbitro_tablero.sv
// Randomised scoreboard bench for arbitro_tablero against a cell-level board model.
module tb_arbitro_tablero;

  localparam int MAXW = 4;
  localparam int WINC = 32;
  localparam int VPER = 60;
`ifdef VBLANK_COMMIT_EN
  localparam bit WinMode = 1'b1;
`else
  localparam bit WinMode = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b0, vsync = 1'b1, limpiar = 1'b0;
  logic        req_j = 1'b0, req_pc = 1'b0, tab_j = 1'b0, tab_pc = 1'b0;
  logic [2:0]  fila_j = '0, fila_pc = '0, col_j = '0, col_pc = '0;
  logic [1:0]  val_j = '0, val_pc = '0;
  logic        ack_j, ack_pc, err_coord, ventana;
  logic [49:0] tablero_jugador, tablero_pc;

  arbitro_tablero #(.MAX_WRITES(MAXW), .WIN_CYCLES(WINC)) dut (
    .clock(clock), .reset(reset), .vsync(vsync),
    .req_j(req_j), .req_pc(req_pc), .tab_j(tab_j), .tab_pc(tab_pc),
    .fila_j(fila_j), .fila_pc(fila_pc), .col_j(col_j), .col_pc(col_pc),
    .val_j(val_j), .val_pc(val_pc), .limpiar(limpiar),
    .ack_j(ack_j), .ack_pc(ack_pc), .err_coord(err_coord), .ventana(ventana),
    .tablero_jugador(tablero_jugador), .tablero_pc(tablero_pc)
  );

  always #10 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        err;
    logic [49:0] bj;
    logic [49:0] bp;
  } exp_t;

  exp_t q_j[$], q_pc[$];
  int   n_vec = 0, n_bad = 0, cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  // Monitor: every ack must match the response predicted for that exact cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      for (int s = 0; s < 2; s++) begin
        logic a;
        bit   have;
        a    = (s == 0) ? ack_j : ack_pc;
        have = (s == 0) ? (q_j.size() > 0 && q_j[0].cyc == cyc)
                        : (q_pc.size() > 0 && q_pc[0].cyc == cyc);
        if (have) e = (s == 0) ? q_j.pop_front() : q_pc.pop_front();
        if (a && !have) chk(s == 0 ? "ack_j_unexpected" : "ack_pc_unexpected", 1, 0);
        else if (!a && have) chk(s == 0 ? "ack_j_missing" : "ack_pc_missing", 0, 1);
        else if (a && have) begin
          chk(s == 0 ? "err_with_ack_j" : "err_with_ack_pc", err_coord, e.err);
          chk("board_j_at_ack", tablero_jugador, e.bj);
          chk("board_pc_at_ack", tablero_pc, e.bp);
        end
      end
      if (!ack_j && !ack_pc) chk("err_without_ack", err_coord, 0);
    end
  end

  // Reference model: boards as flat vectors indexed by 2*(5r+c), plus requester queues.
  bit          ptr, am_j, am_pc, pend, have_j, have_pc, gen_en, did_reset;
  int          st, wc, cc;
  bit          v1, v2, v3;
  logic [49:0] mj, mp;
  logic        it_t[2];
  int          it_f[2], it_c[2], it_v[2];

  task automatic model_reset();
    ptr = 0; am_j = 0; am_pc = 0; pend = 0; have_j = 0; have_pc = 0;
    st = 0; wc = 0; cc = 0; v1 = 1; v2 = 1; v3 = 1; mj = '0; mp = '0;
    q_j.delete(); q_pc.delete();
  endtask

  task automatic new_item(input int s);
    it_t[s] = 1'($urandom_range(0, 1));
    it_f[s] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
    it_c[s] = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
    it_v[s] = $urandom_range(0, 3);
  endtask

  task automatic step(input bit do_limpiar);
    bit   en, clean, ej, ep, gj, gp, ok, pulse;
    int   s, idx;
    exp_t e;
    chk("ventana", ventana, WinMode ? (st != 0) : 1'b1);
    chk("board_j", tablero_jugador, mj);
    chk("board_pc", tablero_pc, mp);
    if (gen_en && !have_j && $urandom_range(0, 2) != 0) begin new_item(0); have_j = 1; end
    if (gen_en && !have_pc && $urandom_range(0, 2) != 0) begin new_item(1); have_pc = 1; end
    req_j  = have_j && !am_j;
    req_pc = have_pc && !am_pc;
    tab_j  = it_t[0]; fila_j = 3'(it_f[0]); col_j = 3'(it_c[0]); val_j = 2'(it_v[0]);
    tab_pc = it_t[1]; fila_pc = 3'(it_f[1]); col_pc = 3'(it_c[1]); val_pc = 2'(it_v[1]);
    vsync   = !((cyc % VPER) < 4);
    limpiar = do_limpiar;
    en    = WinMode ? (st == 2) : !do_limpiar;
    clean = WinMode ? (st == 1) : do_limpiar;
    ej = req_j; ep = req_pc;
    gj = en && ej && (!ep || !ptr);
    gp = en && ep && !gj;
    if (clean) begin mj = '0; mp = '0; end
    if (gj || gp) begin
      s   = gp ? 1 : 0;
      ok  = it_f[s] < 5 && it_c[s] < 5;
      idx = 2 * (5 * it_f[s] + it_c[s]);
      if (ok && it_t[s]) mp[idx +: 2] = 2'(it_v[s]);
      if (ok && !it_t[s]) mj[idx +: 2] = 2'(it_v[s]);
      e.cyc = cyc + 1; e.err = !ok; e.bj = mj; e.bp = mp;
      if (gj) begin q_j.push_back(e); have_j = 0; end
      else begin q_pc.push_back(e); have_pc = 0; end
      ptr = gj;
    end
    am_j = gj; am_pc = gp;
    pulse = v3 && !v2;
    case (st)
      0: begin wc = 0; cc = 0; if (pulse) st = pend ? 1 : 2; end
      1: begin pend = 0; st = 2; end
      default: begin
        cc++;
        if (gj || gp) wc++;
        if (wc == MAXW || cc == WINC) st = 0;
      end
    endcase
    if (do_limpiar) pend = 1;
    v3 = v2; v2 = v1; v1 = vsync;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_j = 0; req_pc = 0; limpiar = 0; vsync = 1;
  endtask

  initial begin
    model_reset();
    gen_en = 1; did_reset = 0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack_j", ack_j, 0);
    chk("rst_ack_pc", ack_pc, 0);
    chk("rst_err", err_coord, 0);
    chk("rst_ventana", ventana, WinMode ? 1'b0 : 1'b1);
    chk("rst_board_j", tablero_jugador, 0);
    chk("rst_board_pc", tablero_pc, 0);
    #5 reset = 1;
    @(posedge clock);
    #1;
    // First write targets the PC board at row 2, column 3 with value 2 (bits 27:26).
    it_t[0] = 1; it_f[0] = 2; it_c[0] = 3; it_v[0] = 2; have_j = 1;
    for (int i = 0; i < 900; i++) begin
      if (i >= 400 && !did_reset && (am_j || am_pc)) begin
        did_reset = 1;
        #3 reset = 0;
        #1;
        chk("midrst_ack_j", ack_j, 0);
        chk("midrst_ack_pc", ack_pc, 0);
        chk("midrst_board_j", tablero_jugador, 0);
        chk("midrst_board_pc", tablero_pc, 0);
        chk("midrst_ventana", ventana, WinMode ? 1'b0 : 1'b1);
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clock);
        #5 reset = 1;
        @(posedge clock);
        #1;
      end
      if (i == 750) gen_en = 0;
      step($urandom_range(0, 39) == 0);
    end
    chk("q_j_drained", q_j.size(), 0);
    chk("q_pc_drained", q_pc.size(), 0);
    chk("req_j_drained", have_j, 0);
    chk("req_pc_drained", have_pc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
